mul_result_formatter: RTL and testbench

Downstream stage of `fast_multiplication`. It consumes the 128-bit product magnitude and its sign bit, and pairs each product in order with the opcode and destination tag recorded when the operands were issued. It forms the signed two's-complement product and selects the 64-bit half the opcode requires. The formatted result is held in an output register behind a valid/ready handshake toward writeback.

---
 rtl/mul_result_formatter.sv | 137 +++++++++++++
 tb/tb_mul_result_formatter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_result_formatter.sv
// mul_result_formatter
// Pairs each multiplier product with the {op, tag} recorded at issue time,
// applies the sign to the product magnitude, selects the 64-bit half the
// opcode asks for and holds it in a valid/ready output register.

module mul_result_formatter #(
    parameter int PRODUCT_WIDTH_IN_BITS = 128,
    parameter int RESULT_WIDTH_IN_BITS  = 64,
    parameter int TAG_WIDTH_IN_BITS     = 5,
    parameter int TAG_FIFO_DEPTH        = 4
) (
    input  logic                             clk_in,
    input  logic                             reset_in,
    input  logic                             issue_valid_in,
    output logic                             issue_ready_out,
    input  logic [1:0]                       issue_op_in,
    input  logic [TAG_WIDTH_IN_BITS-1:0]     issue_tag_in,
    input  logic                             product_valid_in,
    output logic                             product_ready_out,
    input  logic                             product_sign_bit_in,
    input  logic [PRODUCT_WIDTH_IN_BITS-1:0] product_in,
    output logic                             result_valid_out,
    input  logic                             result_ready_in,
    output logic [RESULT_WIDTH_IN_BITS-1:0]  result_out,
    output logic [TAG_WIDTH_IN_BITS-1:0]     result_tag_out,
    output logic                             orphan_error_out
);

    localparam int PTR_W   = $clog2(TAG_FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 + TAG_WIDTH_IN_BITS;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(TAG_FIFO_DEPTH);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b11;

    logic [ENTRY_W-1:0]               fifo_mem [TAG_FIFO_DEPTH];
    logic [PTR_W-1:0]                 wr_ptr;
    logic [PTR_W-1:0]                 rd_ptr;
    logic [CNT_W-1:0]                 count;

    logic                             push;
    logic                             accept;
    logic                             pop;
    logic                             orphan;
    logic [ENTRY_W-1:0]               head_entry;
    logic [1:0]                       head_op;
    logic [TAG_WIDTH_IN_BITS-1:0]     head_tag;
    logic [PRODUCT_WIDTH_IN_BITS-1:0] signed_product;
    logic [RESULT_WIDTH_IN_BITS-1:0]  formatted;

    // Readies depend only on registered state and result_ready_in.
    assign issue_ready_out   = (count != FULL_COUNT);
    assign product_ready_out = !result_valid_out || result_ready_in;

    assign push   = issue_valid_in && issue_ready_out;
    assign accept = product_valid_in && product_ready_out;
    // An op pushed on this edge is not yet counted, so it cannot pair here.
    assign pop    = accept && (count != '0);
    assign orphan = accept && (count == '0);

    assign head_entry = fifo_mem[rd_ptr];
    assign head_op    = head_entry[ENTRY_W-1 -: 2];
    assign head_tag   = head_entry[TAG_WIDTH_IN_BITS-1:0];

    // Two's-complement negate when the sign bit is set; a zero magnitude
    // negates to zero naturally.
    always_comb begin
        signed_product = product_in;
        if (product_sign_bit_in) begin
            signed_product = ~product_in + PRODUCT_WIDTH_IN_BITS'(1);
        end
    end

    // Half selection by opcode; MULHU uses the unsigned magnitude.
    always_comb begin
        formatted = signed_product[PRODUCT_WIDTH_IN_BITS-1 -: RESULT_WIDTH_IN_BITS];
        case (head_op)
            OP_MUL:   formatted = signed_product[RESULT_WIDTH_IN_BITS-1:0];
            OP_MULHU: formatted = product_in[PRODUCT_WIDTH_IN_BITS-1 -: RESULT_WIDTH_IN_BITS];
            default:  formatted = signed_product[PRODUCT_WIDTH_IN_BITS-1 -: RESULT_WIDTH_IN_BITS];
        endcase
    end

    // Tag FIFO storage; contents are only read while count is non-zero.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {issue_op_in, issue_tag_in};
        end
    end

    // Tag FIFO pointers and occupancy.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Output register: load on a paired accept, clear on drain otherwise.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            result_valid_out <= 1'b0;
            result_out       <= '0;
            result_tag_out   <= '0;
        end else if (pop) begin
            result_valid_out <= 1'b1;
            result_out       <= formatted;
            result_tag_out   <= head_tag;
        end else if (result_ready_in) begin
            result_valid_out <= 1'b0;
        end
    end

    // Sticky flag for a product that arrives with no recorded op.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            orphan_error_out <= 1'b0;
        end else if (orphan) begin
            orphan_error_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mul_result_formatter.sv
// Bench for mul_result_formatter: directed steps from the test plan followed
// by random traffic, all checked against a queue-based reference model.

module tb_mul_result_formatter;

    logic         clk_in = 1'b0;
    logic         reset_in;
    logic         issue_valid_in;
    logic         issue_ready_out;
    logic [1:0]   issue_op_in;
    logic [4:0]   issue_tag_in;
    logic         product_valid_in;
    logic         product_ready_out;
    logic         product_sign_bit_in;
    logic [127:0] product_in;
    logic         result_valid_out;
    logic         result_ready_in;
    logic [63:0]  result_out;
    logic [4:0]   result_tag_out;
    logic         orphan_error_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [6:0]  q[$];
    logic        m_valid;
    logic [63:0] m_result;
    logic [4:0]  m_tag;
    logic        m_orphan;

    always #5 clk_in = ~clk_in;

    mul_result_formatter dut (
        .clk_in              (clk_in),
        .reset_in            (reset_in),
        .issue_valid_in      (issue_valid_in),
        .issue_ready_out     (issue_ready_out),
        .issue_op_in         (issue_op_in),
        .issue_tag_in        (issue_tag_in),
        .product_valid_in    (product_valid_in),
        .product_ready_out   (product_ready_out),
        .product_sign_bit_in (product_sign_bit_in),
        .product_in          (product_in),
        .result_valid_out    (result_valid_out),
        .result_ready_in     (result_ready_in),
        .result_out          (result_out),
        .result_tag_out      (result_tag_out),
        .orphan_error_out    (orphan_error_out)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Signed product as a 128-bit number, then the requested half.
    function automatic logic [63:0] ref_fmt(input logic [1:0] op, input logic s,
                                            input logic [127:0] m);
        logic [127:0] p;
        logic [127:0] hi;
        p = s ? (128'd0 - m) : m;
        case (op)
            2'd0:    return p[63:0];
            2'd3:    begin hi = m >> 64; return hi[63:0]; end
            default: begin hi = p >> 64; return hi[63:0]; end
        endcase
    endfunction

    task automatic model_clear();
        q.delete();
        m_valid  = 1'b0;
        m_result = '0;
        m_tag    = '0;
        m_orphan = 1'b0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_valid"},  64'(result_valid_out), 64'(m_valid));
        check({pfx, "_result"}, result_out,             m_result);
        check({pfx, "_tag"},    64'(result_tag_out),   64'(m_tag));
        check({pfx, "_orphan"}, 64'(orphan_error_out), 64'(m_orphan));
    endtask

    // One cycle: drive, check readies, clock, update model, check outputs.
    task automatic step(input logic iv, input logic [1:0] op, input logic [4:0] tag,
                        input logic pv, input logic s, input logic [127:0] m,
                        input logic rr);
        logic exp_ir, exp_pr, acc, psh;
        logic [6:0] e;
        issue_valid_in      = iv;
        issue_op_in         = op;
        issue_tag_in        = tag;
        product_valid_in    = pv;
        product_sign_bit_in = s;
        product_in          = m;
        result_ready_in     = rr;
        #1;
        exp_ir = (q.size() != 4);
        exp_pr = !m_valid || rr;
        check("issue_ready",   64'(issue_ready_out),   64'(exp_ir));
        check("product_ready", 64'(product_ready_out), 64'(exp_pr));
        acc = pv && exp_pr;
        psh = iv && exp_ir;
        @(posedge clk_in);
        if (acc && q.size() == 0) begin
            m_orphan = 1'b1;
            if (rr) m_valid = 1'b0;
        end else if (acc) begin
            e        = q.pop_front();
            m_valid  = 1'b1;
            m_result = ref_fmt(e[6:5], s, m);
            m_tag    = e[4:0];
        end else if (rr) begin
            m_valid = 1'b0;
        end
        if (psh) q.push_back({op, tag});
        #1;
        check_outputs("out");
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] tag);
        step(1'b1, op, tag, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic product(input logic s, input logic [127:0] m);
        step(1'b0, 2'd0, 5'd0, 1'b1, s, m, 1'b1);
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_valid"},   64'(result_valid_out),  64'd0);
        check({pfx, "_result"},  result_out,             64'd0);
        check({pfx, "_tag"},     64'(result_tag_out),    64'd0);
        check({pfx, "_orphan"},  64'(orphan_error_out),  64'd0);
        check({pfx, "_iready"},  64'(issue_ready_out),   64'd1);
        check({pfx, "_pready"},  64'(product_ready_out), 64'd1);
    endtask

    // Hold reset 5 cycles (asserted asynchronously), release at a falling edge.
    task automatic apply_reset();
        reset_in         = 1'b0;
        issue_valid_in   = 1'b0;
        product_valid_in = 1'b0;
        result_ready_in  = 1'b1;
        #1;
        check_reset_state("rst_async");
        repeat (5) begin
            @(posedge clk_in);
            #1;
            check_reset_state("rst_hold");
        end
        @(negedge clk_in);
        reset_in = 1'b1;
        @(posedge clk_in);
        #1;
        model_clear();
        check_reset_state("rst_release");
    endtask

    initial begin
        logic [127:0] big;
        logic [127:0] rm;
        reset_in            = 1'b0;
        issue_valid_in      = 1'b0;
        issue_op_in         = '0;
        issue_tag_in        = '0;
        product_valid_in    = 1'b0;
        product_sign_bit_in = 1'b0;
        product_in          = '0;
        result_ready_in     = 1'b1;
        model_clear();
        apply_reset();

        // MUL / MULH
        issue(2'd0, 5'd3);
        product(1'b0, 128'd14);
        check("mul_pos_const", result_out, 64'd14);
        check("mul_pos_tag", 64'(result_tag_out), 64'd3);
        issue(2'd0, 5'd4);
        product(1'b1, 128'd14);
        check("mul_neg_const", result_out, 64'hFFFF_FFFF_FFFF_FFF2);
        issue(2'd1, 5'd5);
        product(1'b1, 128'd14);
        check("mulh_neg_const", result_out, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(2'd1, 5'd6);
        product(1'b0, 128'd6762);
        check("mulh_small_const", result_out, 64'd0);

        // Zero and MULHU
        issue(2'd1, 5'd7);
        product(1'b1, 128'd0);
        check("mulh_zero_const", result_out, 64'd0);
        big = {64'd0, 64'hFFFF_FFFF_FFFF_FFFF} * {64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        issue(2'd3, 5'd8);
        product(1'b1, big);
        check("mulhu_const", result_out, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(2'd2, 5'd9);
        product(1'b1, big);

        // FIFO full, 5th issue refused, push+pop while full refused
        for (int i = 0; i < 4; i++) issue(2'd0, 5'(i));
        check("full_iready", 64'(issue_ready_out), 64'd0);
        issue(2'd0, 5'd20);
        step(1'b1, 2'd0, 5'd21, 1'b1, 1'b0, 128'd100, 1'b1);
        check("full_pushpop_tag", 64'(result_tag_out), 64'd0);
        check("full_pushpop_iready", 64'(issue_ready_out), 64'd1);
        for (int i = 0; i < 3; i++) product(1'b0, 128'(i + 1));
        check("drain_last_tag", 64'(result_tag_out), 64'd3);

        // Tags in order across pointer wrap
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2'd0, 5'(i % 4), (i > 0), 1'b0, 128'(i * 3), 1'b1);
        end
        product(1'b0, 128'd77);

        // Backpressure: result pending, ready low 3 cycles, then drain+accept
        issue(2'd0, 5'd10);
        issue(2'd0, 5'd11);
        product(1'b0, 128'd500);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 5'd0, 1'b1, 1'b0, 128'd600, 1'b0);
        check("bp_hold_result", result_out, 64'd500);
        step(1'b0, 2'd0, 5'd0, 1'b1, 1'b0, 128'd600, 1'b1);
        check("bp_no_bubble_result", result_out, 64'd600);
        check("bp_no_bubble_valid", 64'(result_valid_out), 64'd1);
        step(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, '0, 1'b1);

        // Random traffic; products only offered when an op is recorded
        for (int i = 0; i < 300; i++) begin
            rm = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) rm = '0;
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                 (q.size() > 0) && ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), rm,
                 ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 2'd0, 5'd0, (q.size() > 0), 1'b1, 128'd123456789, 1'b1);
        end

        // Orphan: sticky, no valid, next pair still formats correctly
        product(1'b1, 128'd55);
        check("orphan_flag", 64'(orphan_error_out), 64'd1);
        check("orphan_novalid", 64'(result_valid_out), 64'd0);
        issue(2'd0, 5'd12);
        product(1'b1, 128'd2);
        check("post_orphan_result", result_out, 64'hFFFF_FFFF_FFFF_FFFE);
        check("post_orphan_sticky", 64'(orphan_error_out), 64'd1);

        // Reset mid-stream with 3 ops queued, then product is orphaned
        issue(2'd0, 5'd1);
        issue(2'd1, 5'd2);
        issue(2'd2, 5'd3);
        apply_reset();
        product(1'b0, 128'd9);
        check("rst_then_orphan", 64'(orphan_error_out), 64'd1);
        check("rst_then_novalid", 64'(result_valid_out), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
